// File: rtl/ospi_pkg.sv
// rtl/ospi_pkg.sv - shared encodings, opcodes and FSM state for the octal-SPI host
package ospi_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_ERASE = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RDATA,
    ST_WDATA,
    ST_END
  } state_e;

  localparam logic [7:0] OPC_READ  = 8'h0B;
  localparam logic [7:0] OPC_WRITE = 8'h02;
  localparam logic [7:0] OPC_ERASE = 8'h20;

  // Index of the final address beat (three beats, MSB byte first)
  localparam logic [3:0] ADDR_LAST = 4'd2;

  function automatic logic [7:0] op_opcode(input op_e op);
    case (op)
      OP_READ:  return OPC_READ;
      OP_WRITE: return OPC_WRITE;
      OP_ERASE: return OPC_ERASE;
      default:  return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] addr_byte(input logic [23:0] addr, input logic [1:0] idx);
    case (idx)
      2'd0:    return addr[23:16];
      2'd1:    return addr[15:8];
      default: return addr[7:0];
    endcase
  endfunction

endpackage

// File: rtl/ospi_sck_gen.sv
// rtl/ospi_sck_gen.sv - OSPI_CLK divider: low half then high half per beat, with edge strobes
module ospi_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic hold,
  output logic ospi_clk,
  output logic rise,
  output logic beat_end
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          active;
  logic          at_last;

  assign active   = run & ~hold;
  assign at_last  = (div_cnt == DIV_LAST);
  // Strobes mark the clk edge on which ospi_clk toggles
  assign rise     = active & ~ospi_clk & at_last;
  assign beat_end = active &  ospi_clk & at_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt  <= '0;
      ospi_clk <= 1'b0;
    end else if (!active) begin
      div_cnt  <= '0;
      ospi_clk <= 1'b0;
    end else if (at_last) begin
      div_cnt  <= '0;
      ospi_clk <= ~ospi_clk;
    end else begin
      div_cnt  <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ospi_host_ctrl.sv
// rtl/ospi_host_ctrl.sv - octal SDR host: request port to opcode/address/dummy/data frames
module ospi_host_ctrl #(
  parameter int CLK_DIV      = 2,
  parameter int DUMMY_CYCLES = 4,
  parameter int CS_MIN_HIGH  = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [23:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  input  logic        hold_req,
  output logic        busy,
  output logic        ospi_clk,
  output logic        ospi_cs_n,
  inout  wire  [7:0]  ospi_io,
  output logic        ospi_hold_n
);
  import ospi_pkg::*;

  localparam int GAP_W = (CS_MIN_HIGH > 0) ? $clog2(CS_MIN_HIGH + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(CS_MIN_HIGH);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [3:0] DUMMY_LAST = 4'((DUMMY_CYCLES > 0) ? DUMMY_CYCLES - 1 : 0);

  state_e           state;
  op_e              op_q;
  logic [23:0]      addr_q;
  logic [7:0]       wdata_q;
  logic [7:0]       rdata_q;
  logic [7:0]       io_out;
  logic             io_oe;
  logic             hold_q;
  logic [3:0]       beat_cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic   frame_run;
  logic   sck_rise;
  logic   sck_beat_end;
  state_e nxt_state;
  logic [3:0] nxt_beat;
  logic [7:0] nxt_io;
  logic   nxt_oe;
  logic   last_beat;

  assign ospi_io   = io_oe ? io_out : 8'hzz;
  assign busy      = ~ospi_cs_n | (gap_cnt != '0);
  assign frame_run = (state != ST_IDLE) && (state != ST_END);

  ospi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .run      (frame_run),
    .hold     (hold_q),
    .ospi_clk (ospi_clk),
    .rise     (sck_rise),
    .beat_end (sck_beat_end)
  );

  // What the next beat looks like once the current one ends
  always_comb begin
    nxt_state = state;
    nxt_beat  = '0;
    nxt_io    = io_out;
    nxt_oe    = io_oe;
    last_beat = 1'b0;
    case (state)
      ST_CMD: begin
        nxt_state = ST_ADDR;
        nxt_io    = addr_byte(addr_q, 2'd0);
        nxt_oe    = 1'b1;
      end
      ST_ADDR: begin
        if (beat_cnt != ADDR_LAST) begin
          nxt_beat = beat_cnt + 4'd1;
          nxt_io   = addr_byte(addr_q, beat_cnt[1:0] + 2'd1);
        end else begin
          case (op_q)
            OP_READ: begin
              nxt_state = (DUMMY_CYCLES > 0) ? ST_DUMMY : ST_RDATA;
              nxt_io    = 8'h00;
              nxt_oe    = 1'b0;
            end
            OP_WRITE: begin
              nxt_state = ST_WDATA;
              nxt_io    = wdata_q;
            end
            default: last_beat = 1'b1;
          endcase
        end
      end
      ST_DUMMY: begin
        nxt_oe = 1'b0;
        if (beat_cnt == DUMMY_LAST) nxt_state = ST_RDATA;
        else                        nxt_beat  = beat_cnt + 4'd1;
      end
      ST_RDATA, ST_WDATA: last_beat = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      op_q        <= OP_READ;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      io_out      <= '0;
      io_oe       <= 1'b0;
      hold_q      <= 1'b0;
      beat_cnt    <= '0;
      gap_cnt     <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      ospi_cs_n   <= 1'b1;
      ospi_hold_n <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_END: begin
          if (state == ST_END) state <= ST_IDLE;
          if (gap_cnt != '0) gap_cnt <= gap_cnt - GAP_ONE;
          cmd_ready <= (gap_cnt == '0) || (gap_cnt == GAP_ONE);
          if (state == ST_IDLE && cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (op_e'(cmd_op) == OP_RSVD) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 8'h00;
            end else begin
              op_q      <= op_e'(cmd_op);
              addr_q    <= cmd_addr;
              wdata_q   <= cmd_wdata;
              state     <= ST_CMD;
              beat_cnt  <= '0;
              ospi_cs_n <= 1'b0;
              io_out    <= op_opcode(op_e'(cmd_op));
              io_oe     <= 1'b1;
            end
          end
        end
        default: begin
          if (hold_q) begin
            if (!hold_req) begin
              hold_q      <= 1'b0;
              ospi_hold_n <= 1'b1;
              state       <= nxt_state;
              beat_cnt    <= nxt_beat;
              io_out      <= nxt_io;
              io_oe       <= nxt_oe;
            end
          end else begin
            if (sck_rise && state == ST_RDATA) rdata_q <= ospi_io;
            if (sck_beat_end) begin
              if (last_beat) begin
                state     <= ST_END;
                ospi_cs_n <= 1'b1;
                io_oe     <= 1'b0;
                io_out    <= 8'h00;
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b0;
                rsp_rdata <= (op_q == OP_READ) ? rdata_q : 8'h00;
                gap_cnt   <= GAP_INIT;
              end else if (hold_req) begin
                // Park between beats: clock low, CS and io left as they are
                hold_q      <= 1'b1;
                ospi_hold_n <= 1'b0;
              end else begin
                state    <= nxt_state;
                beat_cnt <= nxt_beat;
                io_out   <= nxt_io;
                io_oe    <= nxt_oe;
              end
            end
          end
        end
      endcase
    end
  end

endmodule
